// File: rtl/sr_pulse_gen_if.sv
// sr_pulse_gen_if: groups the button inputs and pulse outputs of sr_pulse_gen.
//   set_btn, reset_btn : raw asynchronous button requests (master -> slave)
//   s, r               : registered, mutually exclusive set/reset pulses
//   busy               : pulse generator is in PULSE_S, PULSE_R or HOLD
//   conflict           : one-cycle flag for coincident set/reset edges
//   conflict_cnt       : saturating conflict count (SR_PULSE_GEN_CONFLICT_CNT_EN only)
interface sr_pulse_gen_if;
  logic       set_btn;
  logic       reset_btn;
  logic       s;
  logic       r;
  logic       busy;
  logic       conflict;
`ifdef SR_PULSE_GEN_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;

  modport master (output set_btn, reset_btn, input s, r, busy, conflict, conflict_cnt);
  modport slave  (input set_btn, reset_btn, output s, r, busy, conflict, conflict_cnt);
`else
  modport master (output set_btn, reset_btn, input s, r, busy, conflict);
  modport slave  (input set_btn, reset_btn, output s, r, busy, conflict);
`endif
endinterface

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen: command front end for a clocked SR flip-flop. Each raw button
// is synchronised (2 flops), debounced, rising-edge detected, and the resulting
// requests are sequenced into fixed-width s/r pulses that are never high together.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sr_pulse_gen_if.slave (set_btn, reset_btn in; s, r, busy, conflict out)
// Optional feature: define SR_PULSE_GEN_CONFLICT_CNT_EN to add bus.conflict_cnt,
// an 8-bit saturating count of conflict pulses cleared only by rst.
module sr_pulse_gen #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned PULSE_W   = 2,
  parameter int unsigned HOLDOFF   = 2
) (
  input logic           clk,
  input logic           rst,
  sr_pulse_gen_if.slave bus
);

  localparam int unsigned DBW = 8;
  localparam int unsigned WW  = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PULSE_S = 2'd1;
  localparam logic [1:0] PULSE_R = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES);
  localparam logic [WW-1:0]  PW_LAST = WW'(PULSE_W - 1);
  // Only meaningful when HOLD_EN; the wrapped value for HOLDOFF=0 is never used.
  localparam logic [WW-1:0]  HO_LAST = WW'(HOLDOFF - 1);
  localparam bit             HOLD_EN = (HOLDOFF != 0);

  // Channel index 0 = set button, 1 = reset button.
  logic [1:0]     sync1_q;
  logic [1:0]     sync2_q;
  logic [1:0]     filt_q;
  logic [1:0]     filt_nx;
  logic [1:0]     filt_d_q;
  logic [1:0]     req_q;
  logic [DBW-1:0] db_cnt_q  [2];
  logic [DBW-1:0] db_cnt_nx [2];

  logic [1:0]     state_q, state_nx;
  logic [WW-1:0]  wcnt_q, wcnt_nx;
  logic           pend_v_q, pend_v_nx;
  logic           pend_k_q, pend_k_nx;   // 0 = set, 1 = reset
  logic           s_q, r_q, busy_q, conflict_q;

  logic           set_only;
  logic           rst_only;
  logic           conflict_nx;

  // Debounce: count cycles the synced level disagrees with the filtered level.
  always_comb begin
    filt_nx = filt_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_nx[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if ((db_cnt_q[i] + DBW'(1)) == DB_LAST) begin
          filt_nx[i] = ~filt_q[i];
        end else begin
          db_cnt_nx[i] = db_cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  // Synchroniser, filter and registered rising-edge request per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_d_q    <= '0;
      req_q       <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q     <= {bus.reset_btn, bus.set_btn};
      sync2_q     <= sync1_q;
      filt_q      <= filt_nx;
      filt_d_q    <= filt_q;
      req_q       <= filt_q & ~filt_d_q;
      db_cnt_q[0] <= db_cnt_nx[0];
      db_cnt_q[1] <= db_cnt_nx[1];
    end
  end

  // Coincident requests cancel each other and only raise conflict.
  assign set_only    = req_q[0] & ~req_q[1];
  assign rst_only    = req_q[1] & ~req_q[0];
  assign conflict_nx = req_q[0] & req_q[1];

  // Pulse-sequencing FSM next state, counters, pending slot and outputs.
  always_comb begin
    state_nx  = state_q;
    wcnt_nx   = wcnt_q;
    pend_v_nx = pend_v_q;
    pend_k_nx = pend_k_q;

    case (state_q)
      IDLE: begin
        // Live request beats the pending slot; leaving IDLE empties the slot.
        if (set_only) begin
          state_nx = PULSE_S;
        end else if (rst_only) begin
          state_nx = PULSE_R;
        end else if (pend_v_q) begin
          state_nx = pend_k_q ? PULSE_R : PULSE_S;
        end
        if (state_nx != IDLE) begin
          pend_v_nx = 1'b0;
          pend_k_nx = 1'b0;
          wcnt_nx   = '0;
        end
      end
      PULSE_S, PULSE_R: begin
        if (wcnt_q == PW_LAST) begin
          wcnt_nx  = '0;
          state_nx = HOLD_EN ? HOLD : IDLE;
        end else begin
          wcnt_nx = wcnt_q + WW'(1);
        end
      end
      HOLD: begin
        if (wcnt_q == HO_LAST) begin
          wcnt_nx  = '0;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt_q + WW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        wcnt_nx  = '0;
      end
    endcase

    // While busy the newest single request overwrites the slot.
    if ((state_q != IDLE) && (set_only || rst_only)) begin
      pend_v_nx = 1'b1;
      pend_k_nx = rst_only;
    end
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      pend_v_q   <= 1'b0;
      pend_k_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_nx;
      wcnt_q     <= wcnt_nx;
      pend_v_q   <= pend_v_nx;
      pend_k_q   <= pend_k_nx;
      s_q        <= (state_nx == PULSE_S);
      r_q        <= (state_nx == PULSE_R);
      busy_q     <= (state_nx != IDLE);
      conflict_q <= conflict_nx;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;

`ifdef SR_PULSE_GEN_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt_q;

  // Saturating count of conflict pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else if (conflict_nx && (conflict_cnt_q != 8'hFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 8'(1);
    end
  end

  assign bus.conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb_sr_pulse_gen: directed per-cycle vector table for sr_pulse_gen at default
// parameters, plus a hand-written reset-during-pulse sequence.
module tb_sr_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sr_pulse_gen_if bus ();

  sr_pulse_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic set;
    logic rst;
    logic s;
    logic r;
    logic busy;
    logic conf;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input int n, input logic set, input logic rb,
                     input logic s, input logic r, input logic busy, input logic conf);
    vec_t v;
    v.set = set; v.rst = rb; v.s = s; v.r = r; v.busy = busy; v.conf = conf;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  initial begin
    bus.set_btn   = 1'b0;
    bus.reset_btn = 1'b0;

    // Bounce: high 3, low 1, high 2 never satisfies the 4-cycle filter.
    add(3, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 0, 0, 0);
    add(9, 0, 0, 0, 0, 0, 0);
    // Clean press held 20 cycles: s on rows 7-8, busy rows 7-10, one pulse only.
    add(7, 1, 0, 0, 0, 0, 0);
    add(2, 1, 0, 1, 0, 1, 0);
    add(2, 1, 0, 0, 0, 1, 0);
    add(9, 1, 0, 0, 0, 0, 0);
    add(10, 0, 0, 0, 0, 0, 0);
    // Coincident press: conflict on row 7 only, no pulse.
    add(7, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 1);
    add(2, 1, 1, 0, 0, 0, 0);
    add(10, 0, 0, 0, 0, 0, 0);
    // Set pulse, queued reset after HOLD, then set-then-reset pending: reset wins.
    add(1, 1, 0, 0, 0, 0, 0);
    add(3, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1, 0);
    add(1, 1, 0, 1, 0, 1, 0);
    add(2, 1, 1, 0, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0, 1, 1, 0);
    add(2, 0, 0, 0, 0, 1, 0);
    add(5, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_s", -1, 8'(bus.s), 8'd0);
    chk("reset_r", -1, 8'(bus.r), 8'd0);
    chk("reset_busy", -1, 8'(bus.busy), 8'd0);
    chk("reset_conflict", -1, 8'(bus.conflict), 8'd0);
    rst = 1'b0;

    // Inputs of row i go in before posedge i; outputs are checked at the following negedge.
    for (int i = 0; i < tbl.size(); i++) begin
      bus.set_btn   = tbl[i].set;
      bus.reset_btn = tbl[i].rst;
      @(negedge clk);
      chk("s", i, 8'(bus.s), 8'(tbl[i].s));
      chk("r", i, 8'(bus.r), 8'(tbl[i].r));
      chk("busy", i, 8'(bus.busy), 8'(tbl[i].busy));
      chk("conflict", i, 8'(bus.conflict), 8'(tbl[i].conf));
      chk("s_and_r", i, 8'(bus.s & bus.r), 8'd0);
    end

`ifdef SR_PULSE_GEN_CONFLICT_CNT_EN
    chk("conflict_cnt", -1, bus.conflict_cnt, 8'd1);
`endif

    // Reset between edges while s is high, releasing the button at the same time.
    bus.set_btn = 1'b1;
    repeat (8) @(negedge clk);
    chk("midpulse_s_before", -1, 8'(bus.s), 8'd1);
    chk("midpulse_busy_before", -1, 8'(bus.busy), 8'd1);
    #2;
    rst         = 1'b1;
    bus.set_btn = 1'b0;
    #1;
    chk("midpulse_s_after_rst", -1, 8'(bus.s), 8'd0);
    chk("midpulse_r_after_rst", -1, 8'(bus.r), 8'd0);
    chk("midpulse_busy_after_rst", -1, 8'(bus.busy), 8'd0);
`ifdef SR_PULSE_GEN_CONFLICT_CNT_EN
    chk("conflict_cnt_rst", -1, bus.conflict_cnt, 8'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_rst_s", i, 8'(bus.s), 8'd0);
      chk("post_rst_r", i, 8'(bus.r), 8'd0);
      chk("post_rst_busy", i, 8'(bus.busy), 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
